serial_addsub_wide: RTL and testbench

Byte-serial wide adder/subtractor built around the 8-bit adder/subtractor datapath. It accepts NBYTES-byte operands in one transaction and processes them one byte per clock, LSB byte first, with carry/borrow registered between bytes. It delivers a full-width result with carry-out and signed overflow. It sits directly upstream of the 8-bit adder/subtractor slice, sequencing operand bytes into it, and extends the slice to wide words without a wide carry chain.

---
 rtl/serial_addsub_wide.sv | 148 ++++++++++++++
 tb/tb_serial_addsub_wide.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_wide.sv
// serial_addsub_wide: byte-serial wide adder/subtractor.
// Operands are latched on accept and consumed one byte per clock, LSB first,
// through a single 8-bit add/sub step with the carry registered between bytes.
// The full-width result, carry-out and signed overflow are published together
// on the completion edge, so partial sums never appear on the outputs.
module serial_addsub_wide #(
    parameter int NBYTES = 4,
    localparam int W     = 8 * NBYTES,
    localparam int CW    = (NBYTES > 2) ? $clog2(NBYTES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    input  logic         sel,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  x_q, x_d;          // operand A, shifted right one byte per step
    logic [W-1:0]  y_q, y_d;          // operand B, shifted right one byte per step
    logic          sel_q, sel_d;
    logic          carry_q, carry_d;  // carry/borrow between byte steps
    logic [W-1:0]  acc_q, acc_d;      // result bytes enter at the top and shift down
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Current byte step: lowest byte of the shifted operands.
    logic [7:0] x_byte;
    logic [7:0] y_byte;
    logic [8:0] step_sum;
    logic       step_ovf;
    logic [W-1:0] acc_next;

    // One 8-bit add/sub slice; subtraction feeds the inverted B byte.
    always_comb begin
        x_byte   = x_q[7:0];
        y_byte   = sel_q ? ~y_q[7:0] : y_q[7:0];
        step_sum = {1'b0, x_byte} + {1'b0, y_byte} + 9'(carry_q);
        // Carry into bit 7 differs from carry out exactly when both addend
        // sign bits agree and the sum sign bit disagrees with them.
        step_ovf = (x_byte[7] == y_byte[7]) && (step_sum[7] != x_byte[7]);
        acc_next = {step_sum[7:0], acc_q[W-1:8]};
    end

    // Next-state and output logic for the IDLE/RUN sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        sel_d    = sel_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    sel_d   = sel;
                    carry_d = sel ? ~cin : cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d     = x_q >> 8;
                y_d     = y_q >> 8;
                acc_d   = acc_next;
                carry_d = step_sum[8];
                if (cnt_q == LAST_BYTE) begin
                    result_d = acc_next;
                    cout_d   = step_sum[8];
                    ovf_d    = step_ovf;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            sel_q    <= 1'b0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sel_q    <= sel_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub_wide.sv
// Testbench for serial_addsub_wide (NBYTES = 4): table of directed vectors
// plus hand-written sequences for operand disturbance, back-to-back and
// mid-run reset.
module tb_serial_addsub_wide;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] x, y;
    logic         cin, sel, start;
    logic         busy, done, cout, overflow;
    logic [W-1:0] result;

    serial_addsub_wide #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .y        (y),
        .cin      (cin),
        .sel      (sel),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic         sel;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t         vecs[8];
    int           checks = 0;
    int           errors = 0;
    int           txn_no = 0;
    logic [W-1:0] prev_res;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Observe one transaction starting at the first negedge after its accept
    // edge (sample index 1). busy must be high for samples 1..4, done only at
    // sample 5, and result must hold its old value until done.
    task automatic watch(input vec_t v, input bit disturb);
        int           busy_n = 0;
        int           done_n = 0;
        int           done_idx = 0;
        bit           stable = 1'b1;
        logic [W-1:0] got_res = '0;
        logic         got_cout = 1'b0;
        logic         got_ovf = 1'b0;
        for (int idx = 1; idx <= 8; idx++) begin
            if (idx > 1) @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_idx = idx;
                got_res  = result;
                got_cout = cout;
                got_ovf  = overflow;
            end else if (done_n == 0 && result !== prev_res) begin
                stable = 1'b0;
            end
            if (disturb && idx == 2) begin
                x     = ~x;
                y     = ~y;
                sel   = ~sel;
                cin   = ~cin;
                start = 1'b1;
            end
            if (disturb && idx == 3) start = 1'b0;
        end
        txn_no++;
        $display("txn %0d: x=0x%08h y=0x%08h cin=%0b sel=%0b -> result=0x%08h cout=%0b ovf=%0b (busy %0d cycles, done at %0d)",
                 txn_no, v.x, v.y, v.cin, v.sel, got_res, got_cout, got_ovf, busy_n, done_idx);
        check("busy_cycles", W'(busy_n), W'(NB));
        check("done_count", W'(done_n), W'(1));
        check("done_latency", W'(done_idx), W'(NB + 1));
        check("result_hold_until_done", W'(stable), W'(1));
        check("result", got_res, v.res);
        check("cout", W'(got_cout), W'(v.cout));
        check("overflow", W'(got_ovf), W'(v.ovf));
        prev_res = v.res;
    endtask

    task automatic run_txn(input vec_t v, input bit disturb);
        @(negedge clk);
        x = v.x; y = v.y; cin = v.cin; sel = v.sel; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch(v, disturb);
    endtask

    initial begin
        vec_t v;
        bit   seen;

        //            x             y             cin   sel   result        cout  ovf
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h00000064, 32'h00000032, 1'b1, 1'b1, 32'h00000031, 1'b1, 1'b0};
        vecs[4] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[7] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};

        // Reset state.
        rst = 1'b1; x = '0; y = '0; cin = 1'b0; sel = 1'b0; start = 1'b0;
        prev_res = '0;
        #1;
        check("reset_result", result, '0);
        check("reset_flags", W'({busy, done, cout, overflow}), '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 8; i++) run_txn(vecs[i], 1'b0);

        // Operand/start disturbance during RUN: only the accepted operands count.
        v = '{32'h01020304, 32'h10203040, 1'b0, 1'b0, 32'h11223344, 1'b0, 1'b0};
        run_txn(v, 1'b1);
        start = 1'b0;

        // Back-to-back: start in the done cycle of the previous transaction.
        @(negedge clk);
        x = 32'h000000FF; y = 32'h00000001; cin = 1'b0; sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("b2b_first_done_seen", W'(seen), W'(1));
        check("b2b_first_result", result, 32'h00000100);
        x = 32'h12345678; y = 32'h11111111; cin = 1'b0; sel = 1'b0; start = 1'b1;
        prev_res = 32'h00000100;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_next_cycle", W'(busy), W'(1));
        check("b2b_no_overlap", W'(done), W'(0));
        v = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
        watch(v, 1'b0);

        // Asynchronous reset two cycles into RUN.
        @(negedge clk);
        x = 32'hFFFFFFFF; y = 32'h00000001; cin = 1'b0; sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_result", result, '0);
        check("midrun_reset_flags", W'({busy, done, cout, overflow}), '0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("midrun_no_done_after_release", W'(seen), W'(0));
        prev_res = '0;
        run_txn(vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
